// File: rtl/rs232_fifo_pkg.sv
// Register map and bit positions shared by the buffered rs232 peripheral.
// Used by rs232_fifo_periph; the irq mask bits apply only with RS232_FIFO_IRQ_EN.
package rs232_fifo_pkg;

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrRxData  = 3'd1;
  localparam logic [2:0] AddrRxCount = 3'd2;
  localparam logic [2:0] AddrTsc     = 3'd3;
  localparam logic [2:0] AddrTxCount = 3'd4;
  localparam logic [2:0] AddrIrqMask = 3'd5;

  localparam int unsigned StTxFull     = 0;
  localparam int unsigned StRxNonempty = 1;
  localparam int unsigned StRxOverrun  = 2;
  localparam int unsigned StTxDrop     = 3;

  localparam int unsigned MaskRxNonempty = 0;
  localparam int unsigned MaskTxEmpty    = 1;
  localparam int unsigned MaskRxOverrun  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head. A pop on empty is ignored;
// a push on full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rs232_fifo_periph.sv
// Buffered rs232 peripheral: RX/TX FIFOs, sticky error flags, counts and a timestamp counter.
// Define RS232_FIFO_IRQ_EN to build the irq mask register and registered interrupt.
module rs232_fifo_periph
  import rs232_fifo_pkg::*;
#(
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [2:0]  peri_address,
  input  logic        peri_read,
  input  logic        peri_write,
  input  logic [31:0] peri_writedata,
  output logic [31:0] peri_readdata,
  output logic        peri_readdatavalid,
  input  logic        rs232in_attention,
  input  logic [7:0]  rs232in_data,
  input  logic        rs232out_busy,
  output logic        rs232out_w,
  output logic [7:0]  rs232out_d,
  output logic        irq
);

  logic [7:0]             rx_head, tx_head;
  logic                   rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic                   rx_pop, tx_push, tx_pop, status_rd;
  logic                   rx_overrun_q, tx_drop_q, strobe_q;
  logic [31:0]            tsc_q, readdata_q, read_mux, mask_rd;
  logic                   readdatavalid_q;
  logic                   unused_wdata;

  assign unused_wdata = ^peri_writedata[31:8];

  assign rx_pop    = peri_read && (peri_address == AddrRxData) && !rx_empty;
  assign status_rd = peri_read && (peri_address == AddrStatus);
  assign tx_push   = peri_write && (peri_address == AddrStatus);
  // Holdoff after each strobe covers the serialiser's one-cycle busy latency.
  assign tx_pop    = !rst && !tx_empty && !rs232out_busy && !strobe_q;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (rs232in_attention),
    .pop   (rx_pop),
    .wdata (rs232in_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (peri_writedata[7:0]),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign rs232out_w = tx_pop;
  assign rs232out_d = tx_pop ? tx_head : 8'h00;

  always_comb begin
    read_mux = '0;
    case (peri_address)
      AddrStatus: begin
        read_mux[StTxDrop]     = tx_drop_q;
        read_mux[StRxOverrun]  = rx_overrun_q;
        read_mux[StRxNonempty] = !rx_empty;
        read_mux[StTxFull]     = tx_full;
      end
      AddrRxData:  read_mux[7:0] = rx_empty ? 8'h00 : rx_head;
      AddrRxCount: read_mux = 32'(rx_count);
      AddrTsc:     read_mux = tsc_q;
      AddrTxCount: read_mux = 32'(tx_count);
      AddrIrqMask: read_mux = mask_rd;
      default:     read_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      rx_overrun_q    <= 1'b0;
      tx_drop_q       <= 1'b0;
      strobe_q        <= 1'b0;
      tsc_q           <= '0;
    end else begin
      if (peri_read) readdata_q <= read_mux;
      readdatavalid_q <= peri_read;
      // A new error event in the clearing cycle keeps its flag set.
      rx_overrun_q <= (rx_overrun_q && !status_rd) || (rs232in_attention && rx_full && !rx_pop);
      tx_drop_q    <= (tx_drop_q && !status_rd) || (tx_push && tx_full && !tx_pop);
      strobe_q     <= tx_pop;
      tsc_q        <= tsc_q + 32'd1;
    end
  end

  assign peri_readdata      = readdata_q;
  assign peri_readdatavalid = readdatavalid_q;

`ifdef RS232_FIFO_IRQ_EN
  logic [2:0] mask_q, irq_src;
  logic       irq_q;

  always_comb begin
    irq_src                 = '0;
    irq_src[MaskRxNonempty] = !rx_empty;
    irq_src[MaskTxEmpty]    = tx_empty;
    irq_src[MaskRxOverrun]  = rx_overrun_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (peri_write && (peri_address == AddrIrqMask)) mask_q <= peri_writedata[2:0];
      irq_q <= |(mask_q & irq_src);
    end
  end

  assign mask_rd = {29'd0, mask_q};
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_fifo_periph.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Honours RS232_FIFO_IRQ_EN when checking irq and the mask register.
module tb_rs232_fifo_periph;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  peri_address = '0;
  logic        peri_read = 1'b0;
  logic        peri_write = 1'b0;
  logic [31:0] peri_writedata = '0;
  logic [31:0] peri_readdata;
  logic        peri_readdatavalid;
  logic        rs232in_attention = 1'b0;
  logic [7:0]  rs232in_data = '0;
  logic        rs232out_busy = 1'b0;
  logic        rs232out_w;
  logic [7:0]  rs232out_d;
  logic        irq;

  always #5 clock = ~clock;

  rs232_fifo_periph #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clock              (clock),
    .rst                (rst),
    .peri_address       (peri_address),
    .peri_read          (peri_read),
    .peri_write         (peri_write),
    .peri_writedata     (peri_writedata),
    .peri_readdata      (peri_readdata),
    .peri_readdatavalid (peri_readdatavalid),
    .rs232in_attention  (rs232in_attention),
    .rs232in_data       (rs232in_data),
    .rs232out_busy      (rs232out_busy),
    .rs232out_w         (rs232out_w),
    .rs232out_d         (rs232out_d),
    .irq                (irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          m_ovr, m_drop, m_prev, m_irq, m_valid, model_on;
  logic [31:0] m_tsc, m_rdata;
  logic [2:0]  m_mask;

  function automatic bit m_strobe();
    return (rst == 1'b0) && (txq.size() > 0) && !rs232out_busy && !m_prev;
  endfunction

  task automatic model_step();
    logic [31:0] rv;
    bit rxpop, txpop, srd, ovr, drop, txwr;
    logic [2:0] src;
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_ovr = 0; m_drop = 0; m_prev = 0; m_irq = 0; m_valid = 0;
      m_tsc = '0; m_rdata = '0; m_mask = '0;
      model_on = 1;
      return;
    end
    if (!model_on) return;
    rv = '0;
    case (peri_address)
      3'd0: rv = {28'd0, m_drop, m_ovr, rxq.size() != 0, txq.size() == TXD};
      3'd1: if (rxq.size() > 0) rv = {24'd0, rxq[0]};
      3'd2: rv = 32'(rxq.size());
      3'd3: rv = m_tsc;
      3'd4: rv = 32'(txq.size());
`ifdef RS232_FIFO_IRQ_EN
      3'd5: rv = {29'd0, m_mask};
`endif
      default: rv = '0;
    endcase
    txpop = m_strobe();
    rxpop = peri_read && (peri_address == 3'd1) && (rxq.size() > 0);
    srd   = peri_read && (peri_address == 3'd0);
    txwr  = peri_write && (peri_address == 3'd0);
    ovr   = rs232in_attention && (rxq.size() == RXD) && !rxpop;
    drop  = txwr && (txq.size() == TXD) && !txpop;
    src   = {m_ovr, txq.size() == 0, rxq.size() != 0};
    if (peri_read) m_rdata = rv;
    m_valid = peri_read;
    if (rxpop) void'(rxq.pop_front());
    if (txpop) void'(txq.pop_front());
    if (rs232in_attention && rxq.size() < RXD) rxq.push_back(rs232in_data);
    if (txwr && txq.size() < TXD) txq.push_back(peri_writedata[7:0]);
    m_ovr  = (m_ovr && !srd) || ovr;
    m_drop = (m_drop && !srd) || drop;
`ifdef RS232_FIFO_IRQ_EN
    m_irq = |(m_mask & src);
    if (peri_write && peri_address == 3'd5) m_mask = peri_writedata[2:0];
`else
    m_irq = 1'b0;
    src = '0;
`endif
    m_tsc  = m_tsc + 32'd1;
    m_prev = txpop;
  endtask

  task automatic check_outputs();
    bit ew;
    if (!model_on) return;
    ew = m_strobe();
    check_eq("readdata", peri_readdata, m_rdata);
    check_eq("readdatavalid", 32'(peri_readdatavalid), 32'(m_valid));
    check_eq("tx_strobe", 32'(rs232out_w), 32'(ew));
    check_eq("tx_byte", 32'(rs232out_d), ew ? 32'(txq[0]) : 32'd0);
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    check_outputs();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    peri_address = a; peri_writedata = d; peri_write = 1'b1;
    tick();
    peri_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    peri_address = a; peri_read = 1'b1;
    tick();
    peri_read = 1'b0;
  endtask

  task automatic attn(input logic [7:0] b);
    rs232in_data = b; rs232in_attention = 1'b1;
    tick();
    rs232in_attention = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_readdata", peri_readdata, 32'd0);
    check_eq("rst_valid", 32'(peri_readdatavalid), 32'd0);
    check_eq("rst_strobe", 32'(rs232out_w), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);

    // Three TX bytes with the serialiser idle
    wr(3'd0, 32'h41); wr(3'd0, 32'h42); wr(3'd0, 32'h43);
    repeat (10) tick();
    rd(3'd4);
    check_eq("tx_drained", peri_readdata, 32'd0);

    // RX overrun and ordered drain
    for (int i = 1; i <= 17; i++) attn(8'(i));
    rd(3'd2);
    check_eq("rx_count_full", peri_readdata, 32'd16);
    rd(3'd0);
    check_eq("ovr_set", 32'(peri_readdata[2]), 32'd1);
    rd(3'd0);
    check_eq("ovr_cleared", 32'(peri_readdata[2]), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      rd(3'd1);
      check_eq("rx_order", peri_readdata, 32'(i));
    end
    rd(3'd1);
    check_eq("rx_empty_data", peri_readdata, 32'd0);
    check_eq("rx_empty_valid", 32'(peri_readdatavalid), 32'd1);
    tick();
    check_eq("valid_one_cycle", 32'(peri_readdatavalid), 32'd0);
    rd(3'd2);
    check_eq("rx_count_zero", peri_readdata, 32'd0);

    // TX overflow while the serialiser is busy
    rs232out_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(3'd0, 32'(8'h60 + i));
    rd(3'd4);
    check_eq("tx_count_full", peri_readdata, 32'd16);
    rd(3'd0);
    check_eq("tx_full_flag", 32'(peri_readdata[0]), 32'd1);
    check_eq("tx_drop_flag", 32'(peri_readdata[3]), 32'd1);
    rs232out_busy = 1'b0;
    repeat (40) tick();

    // Push and pop together on a full RX FIFO
    for (int i = 0; i < 16; i++) attn(8'(8'h10 + i));
    peri_address = 3'd1; peri_read = 1'b1;
    rs232in_data = 8'hEE; rs232in_attention = 1'b1;
    tick();
    peri_read = 1'b0; rs232in_attention = 1'b0;
    check_eq("full_pushpop_head", peri_readdata, 32'h10);
    rd(3'd2);
    check_eq("full_pushpop_count", peri_readdata, 32'd16);
    rd(3'd0);
    check_eq("full_pushpop_no_ovr", 32'(peri_readdata[2]), 32'd0);
    for (int i = 0; i < 16; i++) rd(3'd1);
    check_eq("full_pushpop_last", peri_readdata, 32'hEE);

`ifdef RS232_FIFO_IRQ_EN
    wr(3'd5, 32'd1);
    attn(8'h55);
    tick();
    check_eq("irq_rx_set", 32'(irq), 32'd1);
    rd(3'd1);
    tick();
    check_eq("irq_rx_clear", 32'(irq), 32'd0);
`endif

    // Random traffic, including occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst               = ($urandom_range(0, 399) == 0);
      peri_read         = ($urandom_range(0, 2) == 0);
      peri_write        = ($urandom_range(0, 2) == 0);
      peri_address      = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      peri_writedata    = $urandom;
      rs232in_attention = ($urandom_range(0, 2) == 0);
      rs232in_data      = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rs232out_busy = ~rs232out_busy;
      tick();
    end
    rst = 1'b0; peri_read = 1'b0; peri_write = 1'b0;
    rs232in_attention = 1'b0; rs232out_busy = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
